// File: rtl/transmitter_abstraction_pkg.sv
// Shared types and constants for the waveform-to-DAC transmitter.
// Frame word layout: two power-down bits followed by 14-bit offset-binary data.
package transmitter_abstraction_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int CFG_ADDR_W   = 12;
    localparam int PERIOD_CNT_W = 12;

    localparam logic [1:0] DAC_PD_NORMAL = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_GAP
    } tx_state_e;

    typedef struct packed {
        logic                  Enable;
        logic [CFG_ADDR_W-1:0] Length;
    } TRANSMITTER_WR_REGISTERS;

    // Two's-complement sample to DAC frame: flipping the sign bit gives offset binary.
    function automatic logic [FRAME_BITS-1:0] dac_frame_word(input logic [13:0] sample);
        return {DAC_PD_NORMAL, ~sample[13], sample[12:0]};
    endfunction

endpackage

// File: rtl/transmitter_abstraction_dac_shifter.sv
// Serialises one 16-bit DAC frame, MSB first, two clocks per bit.
// SClk is high on the first clock of a bit and low on the second; nSync is low for the whole frame.
module dac_shifter
    import transmitter_abstraction_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] word_i,
    output logic                  idle_o,
    output logic                  sclk_o,
    output logic                  nsync_o,
    output logic                  data_o
);

    localparam int BIT_CNT_W = $clog2(FRAME_BITS);

    logic                  active_q, active_d;
    logic                  phase_q, phase_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            active_q  <= active_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        active_d  = active_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (!active_q) begin
            if (start_i) begin
                active_d  = 1'b1;
                phase_d   = 1'b0;
                bit_cnt_d = '0;
                shift_d   = word_i;
            end
        end else if (!phase_q) begin
            phase_d = 1'b1;
        end else begin
            // Data moves only after the low half, so it is stable across the falling SClk edge.
            phase_d   = 1'b0;
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    assign idle_o  = ~active_q;
    assign nsync_o = ~active_q;
    assign sclk_o  = ~active_q | ~phase_q;
    assign data_o  = active_q & shift_q[FRAME_BITS-1];

endmodule

// File: rtl/transmitter_abstraction.sv
// Trigger-started packet transmitter: reads ipLength samples from waveform RAM
// and sends each as a DAC frame, one frame start every SAMPLE_PERIOD clocks.
module transmitter_abstraction
    import transmitter_abstraction_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 40,
    parameter int ADDR_W        = 12
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic              ipEnable,
    input  logic [ADDR_W-1:0] ipLength,
    input  logic              ipTrigger,
    output logic [ADDR_W-1:0] opAddress,
    input  logic [13:0]       ipReadData,
    output logic              opSClk,
    output logic              opnSync,
    output logic              opData,
    output logic              opBusy,
    output logic              opDone
);

    localparam logic [PERIOD_CNT_W-1:0] FETCH_LAST  = PERIOD_CNT_W'(1);
    localparam logic [PERIOD_CNT_W-1:0] SHIFT_LAST  = PERIOD_CNT_W'(2 * FRAME_BITS - 1);
    localparam logic [PERIOD_CNT_W-1:0] PERIOD_LAST = PERIOD_CNT_W'(SAMPLE_PERIOD - 1);

    tx_state_e               state_q, state_d;
    logic                    trig_q;
    logic [ADDR_W-1:0]       k_q, k_d;
    logic [ADDR_W-1:0]       len_q, len_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [PERIOD_CNT_W-1:0] cnt_q, cnt_d;
    logic                    done_q, done_d;

    TRANSMITTER_WR_REGISTERS wr_regs;
    logic                    trig_rise;
    logic                    shifter_start;
    logic                    shifter_idle;

    assign wr_regs.Enable = ipEnable;
    assign wr_regs.Length = CFG_ADDR_W'(ipLength);
    assign trig_rise      = ipTrigger & ~trig_q;

    // Edge detector resets to 1 so a trigger held high through reset is not an edge.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b1;
            k_q     <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= ipTrigger;
            k_q     <= k_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                cnt_d  = '0;
                if (trig_rise && wr_regs.Enable) begin
                    if (wr_regs.Length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        k_d     = '0;
                        len_d   = ADDR_W'(wr_regs.Length);
                    end
                end
            end
            ST_FETCH: begin
                if (!wr_regs.Enable) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else if (shifter_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + PERIOD_CNT_W'(1);
                if (cnt_q == SHIFT_LAST) begin
                    if (!wr_regs.Enable) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                    end else if (k_q + ADDR_W'(1) == len_q) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        // Next address goes out at the start of Gap so RAM data is ready well before the next frame.
                        state_d = ST_GAP;
                        k_d     = k_q + ADDR_W'(1);
                        addr_d  = k_q + ADDR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (!wr_regs.Enable) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else if (shifter_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shifter_start = 1'b0;
        if (wr_regs.Enable && shifter_idle) begin
            if (state_q == ST_FETCH && cnt_q == FETCH_LAST) begin
                shifter_start = 1'b1;
            end else if (state_q == ST_GAP && cnt_q == PERIOD_LAST) begin
                shifter_start = 1'b1;
            end
        end
        opBusy = (state_q != ST_IDLE);
    end

    assign opAddress = addr_q;
    assign opDone    = done_q;

    dac_shifter u_dac_shifter (
        .clk     (ipClk),
        .rst     (ipReset),
        .start_i (shifter_start),
        .word_i  (dac_frame_word(ipReadData)),
        .idle_o  (shifter_idle),
        .sclk_o  (opSClk),
        .nsync_o (opnSync),
        .data_o  (opData)
    );

endmodule

// File: tb/tb_transmitter_abstraction.sv
// Directed bench: main instance at SAMPLE_PERIOD=40, plus a small-address instance at the minimum period.
module tb_transmitter_abstraction;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 1'b0, trig = 1'b0;
    logic [11:0] len = '0;
    logic [11:0] addr;
    logic [13:0] rdata;
    logic        sclk, nsync, data, busy, done;

    logic        en2 = 1'b0, trig2 = 1'b0;
    logic [5:0]  len2 = '0;
    logic [5:0]  addr2;
    logic [13:0] rdata2;
    logic        sclk2, nsync2, data2, busy2, done2;

    logic [13:0] mem [0:4095];

    int tests = 0;
    int fails = 0;

    transmitter_abstraction #(.SAMPLE_PERIOD(40), .ADDR_W(12)) u_dut (
        .ipClk(clk), .ipReset(rst), .ipEnable(en), .ipLength(len), .ipTrigger(trig),
        .opAddress(addr), .ipReadData(rdata), .opSClk(sclk), .opnSync(nsync),
        .opData(data), .opBusy(busy), .opDone(done)
    );

    transmitter_abstraction #(.SAMPLE_PERIOD(36), .ADDR_W(6)) u_dut_max (
        .ipClk(clk), .ipReset(rst), .ipEnable(en2), .ipLength(len2), .ipTrigger(trig2),
        .opAddress(addr2), .ipReadData(rdata2), .opSClk(sclk2), .opnSync(nsync2),
        .opData(data2), .opBusy(busy2), .opDone(done2)
    );

    // Registered-read RAM models; the second RAM holds its own address as data.
    always @(posedge clk) rdata  <= mem[addr];
    always @(posedge clk) rdata2 <= 14'(addr2);

    // Frame/done recorder for the main instance.
    int          cyc = 0;
    logic        prev_ns = 1'b1;
    int          bitn = 0;
    logic [15:0] cur = '0;
    int          falls[$];
    logic [15:0] frames[$];
    int          dones[$];

    always @(negedge clk) begin
        cyc++;
        if (prev_ns && !nsync) begin
            falls.push_back(cyc);
            bitn = 0;
            cur  = '0;
        end
        if (!nsync && sclk) begin
            cur = {cur[14:0], data};
            bitn++;
            if (bitn == 16) frames.push_back(cur);
        end
        if (done) dones.push_back(cyc);
        prev_ns = nsync;
    end

    // Statistics for the minimum-period, maximum-length instance.
    int          cyc2 = 0;
    logic        prev_ns2 = 1'b1;
    int          bitn2 = 0, low2 = 0;
    logic [15:0] cur2 = '0;
    int          frames2 = 0, bad_gap2 = 0, bad_low2 = 0, bad_word2 = 0;
    int          dones2 = 0, last_fall2 = -1, max_addr2 = 0;

    always @(negedge clk) begin
        cyc2++;
        if (prev_ns2 && !nsync2) begin
            if (last_fall2 >= 0 && (cyc2 - last_fall2) != 36) bad_gap2++;
            last_fall2 = cyc2;
            bitn2 = 0;
            cur2  = '0;
            low2  = 0;
        end
        if (!nsync2) low2++;
        if (!prev_ns2 && nsync2 && low2 != 32) bad_low2++;
        if (!nsync2 && sclk2) begin
            cur2 = {cur2[14:0], data2};
            bitn2++;
            if (bitn2 == 16) begin
                if (cur2 != (16'h2000 | 16'(frames2))) bad_word2++;
                frames2++;
            end
        end
        if (int'(addr2) > max_addr2) max_addr2 = int'(addr2);
        if (done2) dones2++;
        prev_ns2 = nsync2;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        falls.delete();
        frames.delete();
        dones.delete();
    endtask

    // Raises the trigger just after a rising edge; t is the monitor's number for that cycle.
    task automatic start_packet(input logic [11:0] l, output int t);
        len = l;
        @(posedge clk);
        #1;
        trig = 1'b1;
        t = cyc + 1;
    endtask

    task automatic test_reset();
        tick(3);
        tests++; if (nsync !== 1'b1) begin fails++; $display("FAIL reset_nsync: got %b expected 1", nsync); end
        tests++; if (sclk !== 1'b1) begin fails++; $display("FAIL reset_sclk: got %b expected 1", sclk); end
        tests++; if (data !== 1'b0) begin fails++; $display("FAIL reset_data: got %b expected 0", data); end
        tests++; if (addr !== 12'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        en  = 1'b1;
        tick(2);
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_three_frames();
        int t;
        logic [15:0] exp_w [3];
        logic [15:0] got;
        int gf;
        exp_w[0] = 16'h2000; exp_w[1] = 16'h3FFF; exp_w[2] = 16'h0000;
        clear_mon();
        start_packet(12'd3, t);
        tick(2);
        trig = 1'b0;
        len  = 12'd7;
        tick(34);
        tests++; if (addr !== 12'd1 || busy !== 1'b1 || nsync !== 1'b1)
            begin fails++; $display("FAIL gap_state: got addr=%0d busy=%b nsync=%b expected addr=1 busy=1 nsync=1", addr, busy, nsync); end
        tick(100);
        tests++; if (frames.size() != 3) begin fails++; $display("FAIL frame_count: got %0d expected 3", frames.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hxxxx;
            tests++; if (got !== exp_w[i]) begin fails++; $display("FAIL frame_word%0d: got %h expected %h", i, got, exp_w[i]); end
        end
        gf = (falls.size() > 0) ? falls[0] : -1;
        tests++; if (gf != t + 3) begin fails++; $display("FAIL first_fall: got cycle %0d expected %0d", gf, t + 3); end
        for (int i = 1; i < 3; i++) begin
            gf = (falls.size() > i) ? falls[i] - falls[i-1] : -1;
            tests++; if (gf != 40) begin fails++; $display("FAIL fall_spacing%0d: got %0d expected 40", i, gf); end
        end
        tests++; if (dones.size() != 1) begin fails++; $display("FAIL done_count: got %0d expected 1", dones.size()); end
        gf = (dones.size() > 0) ? dones[0] : -1;
        tests++; if (gf != t + 115) begin fails++; $display("FAIL done_cycle: got %0d expected %0d", gf, t + 115); end
        $display("[TB] three frames: %0d frames, %0d done pulses", frames.size(), dones.size());
    endtask

    task automatic test_back_to_back();
        int t;
        int gf;
        clear_mon();
        start_packet(12'd3, t);
        tick(2);
        trig = 1'b0;
        tick(8);
        trig = 1'b1;
        tick(2);
        trig = 1'b0;
        tick(130);
        tests++; if (frames.size() != 3) begin fails++; $display("FAIL retrig_frames: got %0d expected 3", frames.size()); end
        tests++; if (dones.size() != 1) begin fails++; $display("FAIL retrig_dones: got %0d expected 1", dones.size()); end
        gf = (dones.size() > 0) ? dones[0] : -1;
        tests++; if (gf != t + 115) begin fails++; $display("FAIL retrig_done_cycle: got %0d expected %0d", gf, t + 115); end
        $display("[TB] retrigger while busy: %0d frames, %0d done pulses", frames.size(), dones.size());
    endtask

    task automatic test_zero_length();
        int t;
        int gf;
        clear_mon();
        start_packet(12'd0, t);
        tick(1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b expected 0", busy); end
        tick(2);
        trig = 1'b0;
        tick(20);
        tests++; if (falls.size() != 0) begin fails++; $display("FAIL zero_frames: got %0d expected 0", falls.size()); end
        tests++; if (dones.size() != 1) begin fails++; $display("FAIL zero_dones: got %0d expected 1", dones.size()); end
        gf = (dones.size() > 0) ? dones[0] : -1;
        tests++; if (gf != t + 1) begin fails++; $display("FAIL zero_done_cycle: got %0d expected %0d", gf, t + 1); end
        $display("[TB] zero length: done at cycle %0d", gf);
    endtask

    task automatic test_enable_drop();
        int t;
        logic [15:0] got;
        clear_mon();
        start_packet(12'd5, t);
        tick(2);
        trig = 1'b0;
        tick(48);
        en = 1'b0;
        tick(200);
        tests++; if (frames.size() != 2) begin fails++; $display("FAIL endrop_frames: got %0d expected 2", frames.size()); end
        got = (frames.size() > 1) ? frames[1] : 16'hxxxx;
        tests++; if (got !== 16'h3FFF) begin fails++; $display("FAIL endrop_frame2: got %h expected 3fff", got); end
        tests++; if (dones.size() != 0) begin fails++; $display("FAIL endrop_dones: got %0d expected 0", dones.size()); end
        tests++; if (busy !== 1'b0 || nsync !== 1'b1) begin fails++; $display("FAIL endrop_idle: got busy=%b nsync=%b expected busy=0 nsync=1", busy, nsync); end
        en = 1'b1;
        tick(2);
        $display("[TB] enable drop: %0d frames, %0d done pulses", frames.size(), dones.size());
    endtask

    task automatic test_reset_mid_frame();
        int t;
        int gf;
        logic [15:0] got;
        mem[0] = 14'h0000;
        tick(2);
        clear_mon();
        start_packet(12'd1, t);
        tick(18);
        tests++; if (nsync !== 1'b0 || sclk !== 1'b0) begin fails++; $display("FAIL midframe_before: got nsync=%b sclk=%b expected 0 0", nsync, sclk); end
        rst = 1'b1;
        #1;
        tests++; if (nsync !== 1'b1 || sclk !== 1'b1 || data !== 1'b0)
            begin fails++; $display("FAIL midframe_abort: got nsync=%b sclk=%b data=%b expected 1 1 0", nsync, sclk, data); end
        tests++; if (busy !== 1'b0 || addr !== 12'd0 || done !== 1'b0)
            begin fails++; $display("FAIL midframe_ctrl: got busy=%b addr=%0d done=%b expected 0 0 0", busy, addr, done); end
        tick(2);
        rst = 1'b0;
        clear_mon();
        tick(10);
        tests++; if (busy !== 1'b0 || falls.size() != 0) begin fails++; $display("FAIL held_trigger: got busy=%b falls=%0d expected 0 0", busy, falls.size()); end
        trig = 1'b0;
        mem[0] = 14'h1234;
        tick(2);
        start_packet(12'd1, t);
        tick(2);
        trig = 1'b0;
        tick(40);
        gf = (falls.size() > 0) ? falls[0] : -1;
        tests++; if (gf != t + 3) begin fails++; $display("FAIL post_reset_fall: got %0d expected %0d", gf, t + 3); end
        got = (frames.size() > 0) ? frames[0] : 16'hxxxx;
        tests++; if (got !== 16'h3234) begin fails++; $display("FAIL post_reset_word: got %h expected 3234", got); end
        gf = (dones.size() > 0) ? dones[0] : -1;
        tests++; if (dones.size() != 1 || gf != t + 35) begin fails++; $display("FAIL post_reset_done: got count=%0d cycle=%0d expected 1 %0d", dones.size(), gf, t + 35); end
        $display("[TB] reset mid-frame: rerun frame %h", got);
    endtask

    task automatic test_max_length();
        en2  = 1'b1;
        len2 = 6'h3F;
        @(posedge clk);
        #1;
        trig2 = 1'b1;
        tick(2);
        trig2 = 1'b0;
        tick(63 * 36 + 40);
        tests++; if (frames2 != 63) begin fails++; $display("FAIL max_frames: got %0d expected 63", frames2); end
        tests++; if (bad_gap2 != 0) begin fails++; $display("FAIL max_spacing: got %0d bad gaps expected 0", bad_gap2); end
        tests++; if (bad_low2 != 0) begin fails++; $display("FAIL max_frame_len: got %0d bad frames expected 0", bad_low2); end
        tests++; if (bad_word2 != 0) begin fails++; $display("FAIL max_words: got %0d bad words expected 0", bad_word2); end
        tests++; if (max_addr2 != 62) begin fails++; $display("FAIL max_addr: got %0d expected 62", max_addr2); end
        tests++; if (dones2 != 1 || busy2 !== 1'b0) begin fails++; $display("FAIL max_done: got dones=%0d busy=%b expected 1 0", dones2, busy2); end
        $display("[TB] max length: %0d frames, max address %0d", frames2, max_addr2);
    endtask

    initial begin
        mem[0] = 14'h0000;
        mem[1] = 14'h1FFF;
        mem[2] = 14'h2000;
        mem[3] = 14'h0AAA;
        mem[4] = 14'h3555;
        test_reset();
        test_three_frames();
        test_back_to_back();
        test_zero_length();
        test_enable_drop();
        test_reset_mid_frame();
        test_max_length();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/transmitter_abstraction.md
TRANSMITTER_ABSTRACTION -- requirements
Module: transmitter_abstraction

Interface
REQ-001 Parameter: SAMPLE_PERIOD, 40, clocks between successive DAC frame starts; legal range 36..4095.
REQ-002 Parameter: ADDR_W, 12, waveform memory address width.
REQ-003 Port: ipClk  input  1  the block's only clock; all logic on its rising edge.
REQ-004 Port: ipReset  input  1  asynchronous, active-high reset.
REQ-005 Port: ipEnable  input  1  allows the block to accept a trigger.
REQ-006 Port: ipLength  input  ADDR_W  number of samples to transmit per trigger.
REQ-007 Port: ipTrigger  input  1  level trigger; only its rising edge is acted on.
REQ-008 Port: opAddress  output  ADDR_W  waveform RAM read address.
REQ-009 Port: ipReadData  input  14  two's-complement sample; valid exactly 1 clock after opAddress changes.
REQ-010 Port: opSClk  output  1  DAC serial clock.
REQ-011 Port: opnSync  output  1  DAC frame select, active low.
REQ-012 Port: opData  output  1  DAC serial data, MSB first.
REQ-013 Port: opBusy  output  1  high in every state other than Idle.
REQ-014 Port: opDone  output  1  single-cycle pulse when a packet completes.

Function
REQ-015 State machine SHALL have states Idle, Fetch, Shift and Gap.
REQ-016 Idle SHALL drive opnSync=1, opSClk=1, opData=0 and opAddress=0.
REQ-017 A rising edge of ipTrigger while in Idle with ipEnable=1 SHALL start a packet; the edge is registered at cycle T.
REQ-018 Sample counter k SHALL be set to 0 at T and opAddress=0 SHALL be presented at T+1 (Fetch).
REQ-019 ipReadData SHALL be captured at T+2 as frame word {2'b00, ~D[13], D[12:0]}: power-down bits 00, then offset binary.
REQ-020 opnSync SHALL fall at T+3 (Shift) with bit 15 on opData.
REQ-021 Each frame bit SHALL last 2 clocks: opSClk=1 on the first and 0 on the second, so the DAC latches on the falling edge while data is stable.
REQ-022 After 16 bits (32 clocks), opnSync and opSClk SHALL return high and opData SHALL return to 0 (Gap).
REQ-023 Successive opnSync falling edges SHALL be exactly SAMPLE_PERIOD clocks apart.
REQ-024 During Gap, opAddress SHALL advance to k+1 and the next word SHALL be captured no later than 1 clock before the next opnSync fall.
REQ-025 After frame k=ipLength-1 completes, the block SHALL return to Idle and pulse opDone on the first Idle cycle.
REQ-026 ipLength SHALL be sampled at T and held for the whole packet; later changes have no effect on that packet.
REQ-027 ipLength=0: no frame SHALL be emitted, and opDone SHALL pulse at T+1.
REQ-028 Trigger edges while opBusy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 ipEnable falling mid-packet: the current frame SHALL complete, the block SHALL then go to Idle, and opDone SHALL NOT pulse.
REQ-030 The k counter SHALL NOT wrap; ipLength=2^ADDR_W-1 is the maximum packet length.

Reset
REQ-031 While ipReset=1, outputs SHALL immediately take these values: opnSync=1, opSClk=1, opData=0, opAddress=0, opBusy=0, opDone=0; state SHALL be Idle.
REQ-032 Reset mid-frame SHALL abort the frame at once, without completing the current bit.
REQ-033 The trigger edge detector SHALL clear on reset, so a trigger held high through reset release SHALL NOT start a packet.

Structure
REQ-034 The shared package SHALL hold the TRANSMITTER_WR_REGISTERS struct {Enable, Length}, the FRAME_BITS=16 constant and the DAC power-down code constant.
REQ-035 The 16-bit shift register, opSClk generation and opnSync SHALL live in one sub-module, dac_shifter, with a start/word-in/idle handshake.

Verification
REQ-036 Scenario: ipLength=3, RAM holds 0x0000, 0x1FFF, 0x2000, one trigger -> frames 0x2000, 0x3FFF, 0x0000; opnSync falls 40 clocks apart; opDone pulses once.
REQ-037 Scenario: second trigger edge 10 clocks into a packet -> frame count unchanged and no extra opDone.
REQ-038 Scenario: ipLength=0 with a trigger -> opnSync stays high and opDone pulses at T+1.
REQ-039 Scenario: ipEnable dropped during frame 2 of 5 -> frame 2 completes, no frames 3-5, no opDone.
REQ-040 Scenario: ipReset asserted in bit 7 of a frame -> opnSync=1 and opSClk=1 in the same cycle; the next trigger runs normally from address 0.
REQ-041 Scenario: SAMPLE_PERIOD=36, ipLength=4095 -> continuous frames, each with a 4-clock Gap, and opAddress reaches 4094 with no wrap.
